pedal_board: RTL and testbench
==============================

PEDAL_BOARD -- requirements
Module: pedal_board

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: Clk (clock) and Reset_n (reset), with polarity and synchronicity fixed as stated.
REQ-002 Clk  input  1  system clock; one audio sample is processed per rising edge.
REQ-003 Reset_n  input  1  asynchronous active-low reset.
REQ-004 Signal_in  input  16  signed two's-complement audio sample.
REQ-005 Switches  input  18  effect enables [17:12] and parameters [11:0].
REQ-006 Signal_out  output  16  signed two's-complement processed sample, registered.

Function
REQ-007 Signal_in and Switches SHALL be captured together in an input register, and the chain result SHALL be captured in the output register, for a latency of exactly 2 Clk edges.
REQ-008 Switches[17] is the master enable; when it is 0, all effects SHALL be bypassed and Signal_out SHALL equal Signal_in delayed by 2 edges.
REQ-009 When Switches[17] is 1, the enabled stages SHALL apply in this fixed order: gain, clip, crush, tremolo, echo.
REQ-010 A disabled stage SHALL pass its input through unchanged.
REQ-011 Gain (Switches[12]), with G = Switches[3:0]: y = sat16((x*(G+4)) >>> 2); G=0 is unity gain.
REQ-012 Clip (Switches[13]), with T = (Switches[7:4]+1)*2048 - 1: y = x clamped to the range [-T, +T]; Switches[7:4] = 4'hF means no clipping.
REQ-013 Crush (Switches[14]), with N = Switches[11:8]: y = x with its low N bits forced to 0 (masking).
REQ-014 Tremolo (Switches[15]): y = (x * m) >>> 8, where m is an unsigned 8-bit triangle LFO value and the >>> is an arithmetic, flooring shift.
REQ-015 The LFO SHALL reset to 255 counting down.
REQ-016 The LFO SHALL step by 1 every 1024 Clk cycles and SHALL reverse direction at 0 and at 255.
REQ-017 The LFO SHALL run continuously whatever the Switches setting.
REQ-018 Echo (Switches[16]): y = sat16(x + (d >>> 1)), where d is the echo-stage input from exactly 1024 clocks earlier.
REQ-019 The echo delay line (1024x16) SHALL be written every clock with the echo-stage input, even when echo is disabled.
REQ-020 Echo-line entries not written since reset SHALL read as 0, tracked with a fill counter rather than by clearing memory.
REQ-021 sat16 SHALL saturate to the range 16'h8000..16'h7FFF, and all intermediate arithmetic SHALL be wide enough that no overflow occurs before saturation.
REQ-022 A change to Switches SHALL take effect on the sample captured in the same input-register cycle; there SHALL be no glitch or partial mixing.

Reset
REQ-023 Reset_n low SHALL immediately force Signal_out, the input register, the output register, the LFO state, the delay write pointer and the fill counter to their reset values: zeros, except the LFO (255, counting down).
REQ-024 Reset asserted mid-stream SHALL discard all in-flight samples and echo history.
REQ-025 After Reset_n rises, Signal_out SHALL remain 0 until the second rising edge after the first sample is captured.

Verification
REQ-026 Reset: Reset_n=0 with Signal_in=4AF3 -> Signal_out=0000 while reset is held; after release, Signal_out stays 0000 until the 2-edge latency elapses.
REQ-027 Bypass: Switches=00000, Signal_in=4AF3 -> Signal_out=4AF3 two edges later.
REQ-028 Chain (within 1024 clocks of reset): Switches=2F000 with inputs 4AF3, 0005, FA8D in turn -> outputs 07F7, 0004, FA92 (T=2047 clip; m=255).
REQ-029 Switches=3F000 applied within the first 1024 samples -> outputs identical to REQ-028, because echo history reads 0.
REQ-030 Echo: Switches=30000; a one-sample impulse 1000 followed by zeros -> output 1000, then 0000, then 0800 exactly 1024 samples after the impulse.
REQ-031 Gain saturation: Switches=2100F; Signal_in=4AF3 -> 7FFF; Signal_in=8000 -> 8000; Signal_in=0100 -> 04C0.

Source files
------------

// File: rtl/pedal_board.sv
// pedal_board: five-stage guitar effects chain processing one signed
// 16-bit sample per clock.
//
// Stream semantics: there is no handshake. Every rising Clk edge captures
// one (Signal_in, Switches) pair. The processed result of that pair
// appears on Signal_out after the following rising edge, giving two edges
// of latency.
//
// Ports
//   Clk         in   1   system clock, one sample per rising edge
//   Reset_n     in   1   asynchronous active-low reset
//   Signal_in   in  16   signed two's-complement audio sample
//   Switches    in  18   [17] master enable, [16:12] echo/tremolo/crush/
//                        clip/gain enables, [11:8] crush bits,
//                        [7:4] clip level, [3:0] gain
//   Signal_out  out 16   signed processed sample (registered)
//
// Stage order when Switches[17]=1: gain -> clip -> crush -> tremolo -> echo.
module pedal_board (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] Signal_in,
    input  logic [17:0] Switches,
    output logic [15:0] Signal_out
);

    // Input register: sample and switches are captured together, so a
    // switch change applies cleanly to exactly one sample onwards.
    logic signed [15:0] in_sample;
    logic [17:0]        in_sw;
    logic signed [15:0] out_sample;

    // Triangle LFO for tremolo: a 1024-cycle prescaler plus an 8-bit value
    // and a direction flag.
    logic [9:0] lfo_div;
    logic [7:0] lfo_val;
    logic       lfo_down;

    // Echo delay line. The fill counter marks entries not yet written
    // since reset, so those entries read as zero without clearing memory.
    logic signed [15:0] echo_mem [0:1023];
    logic [9:0]         wr_ptr;
    logic [10:0]        fill_cnt;

    logic en_gain, en_clip, en_crush, en_trem, en_echo;
    logic [4:0]         gain_k;
    logic signed [25:0] gain_wide, trem_wide, echo_wide;
    logic signed [16:0] clip_thr, clip_neg, clip_in;
    logic signed [15:0] s_gain, s_clip, s_crush, s_trem, s_echo, echo_d;

    function automatic logic signed [15:0] sat16(input logic signed [25:0] v);
        if (v > 26'sd32767)
            sat16 = 16'sh7FFF;
        else if (v < -26'sd32768)
            sat16 = 16'sh8000;
        else
            sat16 = v[15:0];
    endfunction

    assign en_gain  = in_sw[17] & in_sw[12];
    assign en_clip  = in_sw[17] & in_sw[13];
    assign en_crush = in_sw[17] & in_sw[14];
    assign en_trem  = in_sw[17] & in_sw[15];
    assign en_echo  = in_sw[17] & in_sw[16];

    always_comb begin
        // Gain: multiplier (G+4) with a right shift of 2, so G=0 is unity.
        gain_k    = {1'b0, in_sw[3:0]} + 5'd4;
        gain_wide = ($signed({{10{in_sample[15]}}, in_sample}) *
                     $signed({21'd0, gain_k})) >>> 2;
        s_gain    = en_gain ? sat16(gain_wide) : in_sample;

        // Clip: the threshold is level*2048 + 2047. Level 4'hF disables
        // clipping, so -32768 survives unchanged.
        clip_thr = $signed({2'b00, in_sw[7:4], 11'h7FF});
        clip_neg = -clip_thr;
        clip_in  = $signed({s_gain[15], s_gain});
        s_clip   = s_gain;
        if (en_clip && (in_sw[7:4] != 4'hF)) begin
            if (clip_in > clip_thr)
                s_clip = clip_thr[15:0];
            else if (clip_in < clip_neg)
                s_clip = clip_neg[15:0];
        end

        // Crush: zero the low N bits.
        s_crush = en_crush ? (s_clip & (16'hFFFF << in_sw[11:8])) : s_clip;

        // Tremolo: the arithmetic shift floors toward minus infinity.
        // |x*m/256| < 32768, so the saturation here never triggers.
        trem_wide = ($signed({{10{s_crush[15]}}, s_crush}) *
                     $signed({18'd0, lfo_val})) >>> 8;
        s_trem    = en_trem ? sat16(trem_wide) : s_crush;

        // Echo: the slot at wr_ptr was last written 1024 clocks ago.
        echo_d    = (fill_cnt == 11'd1024) ? echo_mem[wr_ptr] : 16'sd0;
        echo_wide = $signed({{10{s_trem[15]}}, s_trem}) +
                    ($signed({{10{echo_d[15]}}, echo_d}) >>> 1);
        s_echo    = en_echo ? sat16(echo_wide) : s_trem;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            in_sample  <= '0;
            in_sw      <= '0;
            out_sample <= '0;
            lfo_div    <= '0;
            lfo_val    <= 8'd255;
            lfo_down   <= 1'b1;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
        end else begin
            in_sample  <= $signed(Signal_in);
            in_sw      <= Switches;
            out_sample <= s_echo;
            wr_ptr     <= wr_ptr + 10'd1;
            if (fill_cnt != 11'd1024)
                fill_cnt <= fill_cnt + 11'd1;
            lfo_div <= lfo_div + 10'd1;
            if (&lfo_div) begin
                if (lfo_down) begin
                    lfo_val <= lfo_val - 8'd1;
                    if (lfo_val == 8'd1)
                        lfo_down <= 1'b0;
                end else begin
                    lfo_val <= lfo_val + 8'd1;
                    if (lfo_val == 8'd254)
                        lfo_down <= 1'b1;
                end
            end
        end
    end

    // The delay line is written every clock with the echo-stage input,
    // whether or not echo is enabled. It has no reset; validity comes
    // from fill_cnt.
    always_ff @(posedge Clk) begin
        echo_mem[wr_ptr] <= s_trem;
    end

    assign Signal_out = out_sample;

endmodule

// File: tb/tb_pedal_board.sv
// Testbench for pedal_board: a driver issues one sample per clock and pushes
// the expected output into a queue. A monitor pops and compares two edges
// later. Expected values come from directed constants or from a
// sample-indexed reference model of the effect chain.
module tb_pedal_board;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sig_in = 16'h0000;
    logic [17:0] sw = 18'h00000;
    logic [15:0] sig_out;

    pedal_board dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .Signal_in (sig_in),
        .Switches  (sw),
        .Signal_out(sig_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_q[$];
    logic        drove = 1'b0;
    int          n = 0;                  // capture-edge index since reset release
    logic [15:0] hist [0:16383];         // echo-stage input per sample index

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Triangle LFO: 255 down to 0, up to 255, one step per 1024 samples.
    function automatic int lfo_at(input int nn);
        int p;
        p = (nn / 1024) % 510;
        return (p <= 255) ? 255 - p : p - 255;
    endfunction

    task automatic model_step(input int xin, input logic [17:0] s, input int nn,
                              output int echo_in, output int y);
        int x, g, lvl, t, nb, m, d;
        x   = xin;
        g   = s[3:0];
        lvl = s[7:4];
        nb  = s[11:8];
        if (s[17] && s[12]) x = sat((x * (g + 4)) >>> 2);
        if (s[17] && s[13] && lvl != 15) begin
            t = (lvl + 1) * 2048 - 1;
            if (x > t) x = t;
            if (x < -t) x = -t;
        end
        if (s[17] && s[14]) x = x & ~((1 << nb) - 1);
        if (s[17] && s[15]) begin
            m = lfo_at(nn);
            x = (x * m) >>> 8;
        end
        echo_in = x;
        if (s[17] && s[16]) begin
            d = (nn - 1024 >= 1) ? int'($signed(hist[nn - 1024])) : 0;
            x = sat(x + (d >>> 1));
        end
        y = x;
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; drives one sample and advances to the next falling edge.
    task automatic send(input logic [15:0] x, input logic [17:0] s,
                        input bit use_lit, input logic [15:0] lit);
        int ei, y;
        sig_in = x;
        sw     = s;
        n++;
        model_step(int'($signed(x)), s, n, ei, y);
        hist[n] = ei[15:0];
        exp_q.push_back(use_lit ? lit : y[15:0]);
        drove = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset(input int hold);
        #2;
        rst_n = 1'b0;
        drove = 1'b0;
        #1;
        check("async_reset_out", sig_out, 16'h0000);
        exp_q.delete();
        n = 0;
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    logic v1 = 1'b0, v2 = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                v1 = 1'b0;
                v2 = 1'b0;
                #1;
                check("reset_hold", sig_out, 16'h0000);
            end else begin
                v2 = v1;
                v1 = drove;
                #1;
                if (v2) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL queue_underflow: got empty want entry (t=%0t)", $time);
                    end else begin
                        check("sample", sig_out, exp_q.pop_front());
                    end
                end else if (v1) begin
                    check("pre_latency_zero", sig_out, 16'h0000);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int hold_cnt;
        logic [17:0] rs;
        logic [15:0] rx;

        sig_in = 16'h4AF3;
        sw     = 18'h00000;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // bypass and the documented chain vectors
        send(16'h4AF3, 18'h00000, 1, 16'h4AF3);
        send(16'h4AF3, 18'h2F000, 1, 16'h07F7);
        send(16'h0005, 18'h2F000, 1, 16'h0004);
        send(16'hFA8D, 18'h2F000, 1, 16'hFA92);
        send(16'h4AF3, 18'h3F000, 1, 16'h07F7);
        send(16'h0005, 18'h3F000, 1, 16'h0004);
        send(16'hFA8D, 18'h3F000, 1, 16'hFA92);
        // gain saturation
        send(16'h4AF3, 18'h2100F, 1, 16'h7FFF);
        send(16'h8000, 18'h2100F, 1, 16'h8000);
        send(16'h0100, 18'h2100F, 1, 16'h04C0);
        // clip level F is transparent; level 0 clamps to -2047
        send(16'h8000, 18'h220F0, 1, 16'h8000);
        send(16'h8000, 18'h22000, 1, 16'hF801);
        // crush
        send(16'hFA8D, 18'h24400, 1, 16'hFA80);
        send(16'h4AF3, 18'h24F00, 1, 16'h0000);
        // master disabled ignores all stage enables
        send(16'h1234, 18'h1FFFF, 1, 16'h1234);

        // reset mid-stream discards in-flight samples
        do_reset(3);

        // echo impulse
        send(16'h1000, 18'h30000, 1, 16'h1000);
        for (int i = 1; i <= 1026; i++)
            send(16'h0000, 18'h30000, 1, (i == 1024) ? 16'h0800 : 16'h0000);

        // randomized run against the model; spans several LFO steps
        hold_cnt = 0;
        rs = 18'h20000;
        for (int i = 0; i < 5000; i++) begin
            if (hold_cnt == 0) begin
                rs = 18'($urandom_range(0, 18'h1FFFF));
                rs[17] = ($urandom_range(0, 7) != 0);
                hold_cnt = $urandom_range(1, 8);
            end
            hold_cnt--;
            case ($urandom_range(0, 7))
                0: rx = 16'h8000;
                1: rx = 16'h7FFF;
                default: rx = 16'($urandom_range(0, 16'hFFFF));
            endcase
            send(rx, rs, 0, 16'h0000);
        end

        // drain
        drove = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
